// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle for the RISC SPM: IR/status flags in, load/select/write strobes out.
// The master modport is the sequencer side; the slave modport is the processing unit side.
interface control_unit_if #(
  parameter int word_size = 8,
  parameter int Sel1_size = 3,
  parameter int Sel2_size = 3
);
  logic [word_size-1:0] instruction;
  logic                 Zflag;
  logic                 ovflag;
  logic                 mdflag;
  logic                 Load_R0;
  logic                 Load_R1;
  logic                 Load_R2;
  logic                 Load_R3;
  logic                 Load_PC;
  logic                 Inc_PC;
  logic                 Load_IR;
  logic                 Load_Add_R;
  logic                 Load_Reg_Y;
  logic                 Load_Reg_Z;
  logic                 Load_Reg_ov;
  logic                 Load_Reg_md;
  logic [Sel1_size-1:0] Sel_Bus_1_Mux;
  logic [Sel2_size-1:0] Sel_Bus_2_Mux;
  logic                 write;
  logic                 halted;
  logic                 err_illegal;
  logic                 err_mul_to;

  modport master (
    input  instruction, Zflag, ovflag, mdflag,
    output Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC, Load_IR, Load_Add_R,
           Load_Reg_Y, Load_Reg_Z, Load_Reg_ov, Load_Reg_md, Sel_Bus_1_Mux, Sel_Bus_2_Mux,
           write, halted, err_illegal, err_mul_to
  );

  modport slave (
    output instruction, Zflag, ovflag, mdflag,
    input  Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC, Load_IR, Load_Add_R,
           Load_Reg_Y, Load_Reg_Z, Load_Reg_ov, Load_Reg_md, Sel_Bus_1_Mux, Sel_Bus_2_Mux,
           write, halted, err_illegal, err_mul_to
  );
endinterface

// File: rtl/control_unit_fsm.sv
// RISC SPM sequencer: fetch/decode/execute FSM with a watchdog-guarded MUL wait and a sticky-error HALT.
// Strobes are decoded from the state register (and Z/ov in the conditional branch states).
module control_unit_fsm #(
  parameter int word_size   = 8,
  parameter int op_size     = 4,
  parameter int Sel1_size   = 3,
  parameter int Sel2_size   = 3,
  parameter int MUL_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  control_unit_if.master bus
);
  localparam int cnt_w = $clog2(MUL_TIMEOUT);
  localparam logic [cnt_w-1:0] CNT_ONE  = cnt_w'(1);
  localparam logic [cnt_w-1:0] CNT_LAST = cnt_w'(MUL_TIMEOUT - 1);

  localparam logic [op_size-1:0] OP_NOP  = 4'h0;
  localparam logic [op_size-1:0] OP_ADD  = 4'h1;
  localparam logic [op_size-1:0] OP_SUB  = 4'h2;
  localparam logic [op_size-1:0] OP_AND  = 4'h3;
  localparam logic [op_size-1:0] OP_NOT  = 4'h4;
  localparam logic [op_size-1:0] OP_RD   = 4'h5;
  localparam logic [op_size-1:0] OP_WR   = 4'h6;
  localparam logic [op_size-1:0] OP_BR   = 4'h7;
  localparam logic [op_size-1:0] OP_BRZ  = 4'h8;
  localparam logic [op_size-1:0] OP_MUL  = 4'h9;
  localparam logic [op_size-1:0] OP_BROV = 4'hA;
  localparam logic [op_size-1:0] OP_HALT = 4'hF;

  localparam logic [Sel1_size-1:0] SEL1_PC    = 3'd4;
  localparam logic [Sel2_size-1:0] SEL2_ALU   = 3'd0;
  localparam logic [Sel2_size-1:0] SEL2_BUS1  = 3'd1;
  localparam logic [Sel2_size-1:0] SEL2_MEM   = 3'd2;
  localparam logic [Sel2_size-1:0] SEL2_MLSB  = 3'd3;
  localparam logic [Sel2_size-1:0] SEL2_MMSB  = 3'd4;

  typedef enum logic [4:0] {
    S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1, S_RD1, S_RD2, S_WR1, S_WR2,
    S_BR1, S_BR2, S_BZ1, S_BO1, S_MUL_W, S_MUL2, S_MUL3, S_HALT
  } state_t;

  state_t           state_r, state_s;
  logic [cnt_w-1:0] cnt_r, cnt_s;
  logic             err_illegal_r, err_illegal_s;
  logic             err_mul_to_r, err_mul_to_s;

  logic [op_size-1:0]   opcode_s;
  logic [1:0]           src_s, dst_s;
  logic [3:0]           src_oh_s, dst_oh_s;
  logic [3:0]           load_r_s;
  logic                 load_pc_s, inc_pc_s, load_ir_s, load_add_r_s, load_reg_y_s;
  logic                 load_reg_z_s, load_reg_ov_s, load_reg_md_s, write_s, halted_s;
  logic                 err_illegal_out_s, err_mul_to_out_s, br_flag_s;
  logic [Sel1_size-1:0] sel1_s;
  logic [Sel2_size-1:0] sel2_s;

  assign opcode_s  = bus.instruction[word_size-1 -: op_size];
  assign src_s     = bus.instruction[3:2];
  assign dst_s     = bus.instruction[1:0];
  assign src_oh_s  = 4'b0001 << src_s;
  assign dst_oh_s  = 4'b0001 << dst_s;
  assign br_flag_s = (state_r == S_BZ1) ? bus.Zflag : bus.ovflag;

  // State, watchdog counter and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      cnt_r         <= '0;
      err_illegal_r <= 1'b0;
      err_mul_to_r  <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      err_illegal_r <= err_illegal_s;
      err_mul_to_r  <= err_mul_to_s;
    end
  end

  // Next-state and strobe decode; reset forces every output low in the same cycle
  always_comb begin
    state_s = state_r;  cnt_s = cnt_r;
    err_illegal_s = err_illegal_r;  err_mul_to_s = err_mul_to_r;
    load_r_s = 4'b0000;  load_pc_s = 1'b0;  inc_pc_s = 1'b0;  load_ir_s = 1'b0;
    load_add_r_s = 1'b0;  load_reg_y_s = 1'b0;  load_reg_z_s = 1'b0;  load_reg_ov_s = 1'b0;
    load_reg_md_s = 1'b0;  write_s = 1'b0;  halted_s = 1'b0;
    err_illegal_out_s = 1'b0;  err_mul_to_out_s = 1'b0;
    sel1_s = '0;  sel2_s = '0;
    if (rst) begin
      state_s = S_IDLE;  cnt_s = '0;  err_illegal_s = 1'b0;  err_mul_to_s = 1'b0;
    end else begin
      err_illegal_out_s = err_illegal_r;
      err_mul_to_out_s  = err_mul_to_r;
      case (state_r)
        S_IDLE: state_s = S_FET1;
        S_FET1: begin
          sel1_s = SEL1_PC;  sel2_s = SEL2_BUS1;  load_add_r_s = 1'b1;  state_s = S_FET2;
        end
        S_FET2: begin
          sel2_s = SEL2_MEM;  load_ir_s = 1'b1;  inc_pc_s = 1'b1;  state_s = S_DEC;
        end
        S_DEC: begin
          case (opcode_s)
            OP_NOP: state_s = S_FET1;
            OP_ADD, OP_SUB, OP_AND, OP_MUL: begin
              sel1_s = Sel1_size'(src_s);  sel2_s = SEL2_BUS1;  load_reg_y_s = 1'b1;
              cnt_s = '0;
              if (opcode_s == OP_MUL) begin
                state_s = S_MUL_W;
              end else begin
                state_s = S_EX1;
              end
            end
            OP_NOT: begin
              sel1_s = Sel1_size'(src_s);  sel2_s = SEL2_ALU;  load_r_s = dst_oh_s;
              load_reg_z_s = 1'b1;  load_reg_ov_s = 1'b1;  state_s = S_FET1;
            end
            OP_RD, OP_WR, OP_BR, OP_BRZ, OP_BROV: begin
              sel1_s = SEL1_PC;  sel2_s = SEL2_BUS1;  load_add_r_s = 1'b1;
              case (opcode_s)
                OP_RD:   state_s = S_RD1;
                OP_WR:   state_s = S_WR1;
                OP_BR:   state_s = S_BR1;
                OP_BRZ:  state_s = S_BZ1;
                OP_BROV: state_s = S_BO1;
                default: state_s = S_HALT;
              endcase
            end
            OP_HALT: state_s = S_HALT;
            default: begin
              state_s = S_HALT;  err_illegal_s = 1'b1;
            end
          endcase
        end
        S_EX1: begin
          sel1_s = Sel1_size'(dst_s);  sel2_s = SEL2_ALU;  load_r_s = dst_oh_s;
          load_reg_z_s = 1'b1;  load_reg_ov_s = 1'b1;  state_s = S_FET1;
        end
        S_RD1, S_WR1: begin
          sel2_s = SEL2_MEM;  load_add_r_s = 1'b1;  inc_pc_s = 1'b1;
          state_s = (state_r == S_RD1) ? S_RD2 : S_WR2;
        end
        S_RD2: begin
          sel2_s = SEL2_MEM;  load_r_s = dst_oh_s;  state_s = S_FET1;
        end
        S_WR2: begin
          sel1_s = Sel1_size'(src_s);  write_s = 1'b1;  state_s = S_FET1;
        end
        S_BR1: begin
          sel2_s = SEL2_MEM;  load_add_r_s = 1'b1;  state_s = S_BR2;
        end
        S_BR2: begin
          sel2_s = SEL2_MEM;  load_pc_s = 1'b1;  state_s = S_FET1;
        end
        S_BZ1, S_BO1: begin
          if (br_flag_s) begin
            sel2_s = SEL2_MEM;  load_add_r_s = 1'b1;  state_s = S_BR2;
          end else begin
            inc_pc_s = 1'b1;  state_s = S_FET1;
          end
        end
        // mdflag seen on the first wait cycle predates this MUL, so only later cycles count
        S_MUL_W: begin
          sel1_s = Sel1_size'(dst_s);  load_reg_md_s = 1'b1;  cnt_s = cnt_r + CNT_ONE;
          if ((cnt_r != '0) && bus.mdflag) begin
            state_s = S_MUL2;
          end else if (cnt_r == CNT_LAST) begin
            state_s = S_HALT;  err_mul_to_s = 1'b1;
          end else begin
            state_s = S_MUL_W;
          end
        end
        S_MUL2: begin
          sel2_s = SEL2_MLSB;  load_r_s = dst_oh_s;  load_reg_z_s = 1'b1;  state_s = S_MUL3;
        end
        S_MUL3: begin
          sel2_s = SEL2_MMSB;  load_r_s = src_oh_s;  state_s = S_FET1;
        end
        S_HALT: halted_s = 1'b1;
        default: state_s = S_HALT;
      endcase
    end
  end

  assign bus.Load_R0       = load_r_s[0];
  assign bus.Load_R1       = load_r_s[1];
  assign bus.Load_R2       = load_r_s[2];
  assign bus.Load_R3       = load_r_s[3];
  assign bus.Load_PC       = load_pc_s;
  assign bus.Inc_PC        = inc_pc_s;
  assign bus.Load_IR       = load_ir_s;
  assign bus.Load_Add_R    = load_add_r_s;
  assign bus.Load_Reg_Y    = load_reg_y_s;
  assign bus.Load_Reg_Z    = load_reg_z_s;
  assign bus.Load_Reg_ov   = load_reg_ov_s;
  assign bus.Load_Reg_md   = load_reg_md_s;
  assign bus.Sel_Bus_1_Mux = sel1_s;
  assign bus.Sel_Bus_2_Mux = sel2_s;
  assign bus.write         = write_s;
  assign bus.halted        = halted_s;
  assign bus.err_illegal   = err_illegal_out_s;
  assign bus.err_mul_to    = err_mul_to_out_s;
endmodule

// File: tb/tb_control_unit_fsm.sv
// Scoreboard bench for control_unit_fsm: per-instruction expected strobe sequences are queued by the
// stimulus and popped/compared every falling edge by an independent monitor.
module tb_control_unit_fsm;
  localparam int TO = 16;

  typedef struct packed {
    logic [3:0] load_r;
    logic       load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, load_reg_ov, load_reg_md;
    logic [2:0] sel1, sel2;
    logic       write, halted, err_illegal, err_mul_to;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  control_unit_if #(.word_size(8), .Sel1_size(3), .Sel2_size(3)) bus ();

  control_unit_fsm #(.word_size(8), .op_size(4), .Sel1_size(3), .Sel2_size(3), .MUL_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  obs_t  obs;
  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  assign obs = {bus.Load_R3, bus.Load_R2, bus.Load_R1, bus.Load_R0, bus.Load_PC, bus.Inc_PC,
                bus.Load_IR, bus.Load_Add_R, bus.Load_Reg_Y, bus.Load_Reg_Z, bus.Load_Reg_ov,
                bus.Load_Reg_md, bus.Sel_Bus_1_Mux, bus.Sel_Bus_2_Mux, bus.write, bus.halted,
                bus.err_illegal, bus.err_mul_to};

  // Monitor: one expected vector per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s @%0t ir=%h: got %h expected %h", t, $time, bus.instruction, obs, e);
      end
    end
  end

  function automatic logic [3:0] oh(input logic [1:0] r);
    return 4'b0001 << r;
  endfunction

  task automatic step(input obs_t e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_in();
    bus.Zflag  = 1'($urandom_range(0, 1));
    bus.ovflag = 1'($urandom_range(0, 1));
    bus.mdflag = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;  rand_in();  step('0, "rst_cyc1");
    rand_in();  step('0, "rst_cyc2");
    rst = 1'b0;  rand_in();  step('0, "idle");
  endtask

  task automatic halt_seq(input logic ei, input logic em);
    obs_t e;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      bus.instruction = 8'($urandom);
      e = '0;  e.halted = 1'b1;  e.err_illegal = ei;  e.err_mul_to = em;
      step(e, "halt");
    end
    do_reset();
  endtask

  task automatic fetch();
    obs_t e;
    rand_in();  bus.instruction = 8'($urandom);
    e = '0;  e.sel1 = 3'd4;  e.sel2 = 3'd1;  e.load_add_r = 1'b1;
    step(e, "fet1");
    rand_in();  bus.instruction = 8'($urandom);
    e = '0;  e.sel2 = 3'd2;  e.load_ir = 1'b1;  e.inc_pc = 1'b1;
    step(e, "fet2");
  endtask

  // Reference: instruction-level description of the expected strobe sequence, cycle by cycle
  task automatic exec(input logic [7:0] ir, input logic f, input int mdk);
    obs_t       e;
    obs_t       addr_pc;
    logic [3:0] op;
    logic [1:0] src, dst;
    bit         done;
    int         k;
    op = ir[7:4];  src = ir[3:2];  dst = ir[1:0];
    addr_pc = '0;  addr_pc.sel1 = 3'd4;  addr_pc.sel2 = 3'd1;  addr_pc.load_add_r = 1'b1;
    fetch();
    bus.instruction = ir;
    rand_in();
    case (op)
      4'h0: step('0, "dec_nop");
      4'h1, 4'h2, 4'h3: begin
        e = '0;  e.sel1 = {1'b0, src};  e.sel2 = 3'd1;  e.load_reg_y = 1'b1;  step(e, "dec_alu");
        rand_in();
        e = '0;  e.sel1 = {1'b0, dst};  e.load_r = oh(dst);  e.load_reg_z = 1'b1;  e.load_reg_ov = 1'b1;
        step(e, "ex1");
      end
      4'h4: begin
        e = '0;  e.sel1 = {1'b0, src};  e.load_r = oh(dst);  e.load_reg_z = 1'b1;  e.load_reg_ov = 1'b1;
        step(e, "dec_not");
      end
      4'h5, 4'h6: begin
        step(addr_pc, "dec_mem");
        rand_in();
        e = '0;  e.sel2 = 3'd2;  e.load_add_r = 1'b1;  e.inc_pc = 1'b1;  step(e, "mem1");
        rand_in();
        e = '0;
        if (op == 4'h5) begin
          e.sel2 = 3'd2;  e.load_r = oh(dst);
        end else begin
          e.sel1 = {1'b0, src};  e.write = 1'b1;
        end
        step(e, "mem2");
      end
      4'h7, 4'h8, 4'hA: begin
        step(addr_pc, "dec_br");
        rand_in();
        if (op == 4'h8) bus.Zflag = f;
        if (op == 4'hA) bus.ovflag = f;
        if (op == 4'h7 || f) begin
          e = '0;  e.sel2 = 3'd2;  e.load_add_r = 1'b1;  step(e, "br1");
          rand_in();
          e = '0;  e.sel2 = 3'd2;  e.load_pc = 1'b1;  step(e, "br2");
        end else begin
          e = '0;  e.inc_pc = 1'b1;  step(e, "br_skip");
        end
      end
      4'h9: begin
        e = '0;  e.sel1 = {1'b0, src};  e.sel2 = 3'd1;  e.load_reg_y = 1'b1;  step(e, "dec_mul");
        done = 1'b0;  k = 0;
        while (!done && k < TO) begin
          rand_in();
          if (k != 0) bus.mdflag = (k == mdk);
          e = '0;  e.sel1 = {1'b0, dst};  e.load_reg_md = 1'b1;  step(e, "mul_w");
          if (k != 0 && k == mdk) done = 1'b1;
          k++;
        end
        if (done) begin
          rand_in();
          e = '0;  e.sel2 = 3'd3;  e.load_r = oh(dst);  e.load_reg_z = 1'b1;  step(e, "mul2");
          rand_in();
          e = '0;  e.sel2 = 3'd4;  e.load_r = oh(src);  step(e, "mul3");
        end else begin
          halt_seq(1'b0, 1'b1);
        end
      end
      4'hF: begin
        step('0, "dec_halt");
        halt_seq(1'b0, 1'b0);
      end
      default: begin
        step('0, "dec_illegal");
        halt_seq(1'b1, 1'b0);
      end
    endcase
  endtask

  task automatic mul_then_reset(input logic [7:0] ir);
    obs_t e;
    fetch();
    bus.instruction = ir;
    rand_in();
    e = '0;  e.sel1 = {1'b0, ir[3:2]};  e.sel2 = 3'd1;  e.load_reg_y = 1'b1;  step(e, "dec_mul");
    for (int i = 0; i < 3; i++) begin
      rand_in();
      if (i != 0) bus.mdflag = 1'b0;
      e = '0;  e.sel1 = {1'b0, ir[1:0]};  e.load_reg_md = 1'b1;  step(e, "mul_w_pre_rst");
    end
    do_reset();
  endtask

  initial begin
    bus.instruction = 8'h00;
    bus.Zflag = 1'b0;  bus.ovflag = 1'b0;  bus.mdflag = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    exec(8'hC0, 1'b0, 0);
    mul_then_reset(8'h96);
    exec(8'h16, 1'b0, 0);
    exec(8'h80, 1'b0, 0);
    exec(8'h80, 1'b1, 0);
    exec(8'hA3, 1'b1, 0);
    exec(8'hA3, 1'b0, 0);
    exec(8'h96, 1'b0, 2);
    exec(8'h95, 1'b0, 1);
    exec(8'h9B, 1'b0, TO - 1);
    exec(8'h4E, 1'b0, 0);
    exec(8'h5B, 1'b0, 0);
    exec(8'h69, 1'b0, 0);
    exec(8'h70, 1'b0, 0);
    exec(8'h00, 1'b0, 0);
    exec(8'h96, 1'b0, 99);
    exec(8'hF0, 1'b0, 0);
    for (int n = 0; n < 200; n++) begin
      exec(8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(1, TO)));
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
